mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Handshake and memory-bus bundle between the I/D caches, the arbiter and the line memory.
// The master modport is the arbiter's view; slave is the caches-plus-memory side.
interface mem_arbiter_if #(
  parameter int LINE_W = 128
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_valid;
  logic [LINE_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_valid;
  logic [LINE_W-1:0] d_rdata;

  logic [31:0]       mem_addr;
  logic              mem_we;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;

  logic              arb_busy;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_valid, i_rdata, d_valid, d_rdata, mem_addr, mem_we, mem_wdata, arb_busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_valid, i_rdata, d_valid, d_rdata, mem_addr, mem_we, mem_wdata, arb_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) round-robin arbiter in front of a fixed-latency line memory.
// One access at a time: IDLE -> BUSY (MEM_LATENCY cycles) -> RESP (one-cycle valid) -> IDLE.
module mem_arbiter #(
  parameter int MEM_LATENCY = 3,
  parameter int LINE_W      = 128
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);
  localparam int         NUM_REQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  // Requester index: 0 = I, 1 = D. Doubles as the round-robin history.
  logic              grant_reg, grant_next;
  logic [31:0]       addr_reg, addr_next;
  logic              we_reg, we_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;

  logic [NUM_REQ-1:0] req;
  logic               pick_d;
  logic               sample;
  logic [NUM_REQ-1:0] valid;
  logic [LINE_W-1:0]  rdata_reg [NUM_REQ];

  assign req = {bus.d_req, bus.i_req};

  // On a tie the requester not granted last wins; a sole requester always wins.
  assign pick_d = (req == 2'b11) ? ~grant_reg : req[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      grant_reg <= 1'b1;
      addr_reg  <= 32'd0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      addr_reg  <= addr_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    addr_next  = addr_reg;
    we_next    = we_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next = pick_d;
          addr_next  = (pick_d ? bus.d_addr : bus.i_addr) & 32'hFFFF_FFF0;
          we_next    = pick_d & bus.d_we;
          wdata_next = pick_d ? bus.d_wdata : '0;
          cnt_next   = CNT_LOAD;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory read data is only guaranteed on the final BUSY cycle.
  assign sample = (state_reg == BUSY) && (cnt_reg == 4'd0) && !we_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          rdata_reg[gi] <= '0;
        end else if (sample && (grant_reg == 1'(gi))) begin
          rdata_reg[gi] <= bus.mem_rdata;
        end
      end

      assign valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
    end
  endgenerate

  assign bus.i_valid   = valid[0];
  assign bus.d_valid   = valid[1];
  assign bus.i_rdata   = rdata_reg[0];
  assign bus.d_rdata   = rdata_reg[1];
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_we    = (state_reg == BUSY) && we_reg;
  assign bus.arb_busy  = (state_reg != IDLE);

endmodule
